// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter sharing one block_ram TileLink-UL slave between two masters.
// Out-of-window requests are answered locally with an error at the RAM's latency.

package tilelink_pkg;

    localparam int SOURCE_W = 4;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [1:0]          a_size;
        logic [SOURCE_W-1:0] a_source;
        logic [31:0]         a_address;
        logic [3:0]          a_mask;
        logic [31:0]         a_data;
        logic                d_ready;
    } tilelink_a;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [1:0]          d_param;
        logic [1:0]          d_size;
        logic [SOURCE_W-1:0] d_source;
        logic                d_sink;
        logic [31:0]         d_data;
        logic                d_error;
        logic                d_ready;
    } tilelink_d;

endpackage

module block_ram_arbiter
    import tilelink_pkg::*;
#(
    parameter logic [31:0] addr_mask = 32'hF000_0000,
    parameter logic [31:0] addr_tag  = 32'h0000_0000
) (
    input  logic      clock,
    input  logic      reset_n,
    input  tilelink_a m0_tla,
    input  tilelink_a m1_tla,
    output logic      m0_a_ready,
    output logic      m1_a_ready,
    output tilelink_d m0_tld,
    output tilelink_d m1_tld,
    output tilelink_a ram_tla,
    input  tilelink_d ram_tld
);

    // One in-flight beat: forwarded to RAM (valid) or answered locally (err).
    typedef struct packed {
        logic                valid;
        logic                err;
        logic                owner;
        logic [SOURCE_W-1:0] source;
    } stage_t;

    logic      last_q, last_d;
    stage_t    s1_q, s1_d;
    stage_t    s2_q, s2_d;
    tilelink_a ram_tla_q, ram_tla_d;
    logic      stray_q, stray_d;

    logic      gnt_valid;
    logic      gnt_idx;
    tilelink_a gnt_req;
    logic      hit;
    tilelink_d idle_rsp;
    tilelink_d owner_rsp;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (m0_tla.a_valid && m1_tla.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = ~last_q;
        end else if (m0_tla.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b0;
        end else if (m1_tla.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b1;
        end
    end

    // Grants are masked by reset itself so they drop asynchronously with it.
    assign m0_a_ready = reset_n & gnt_valid & ~gnt_idx;
    assign m1_a_ready = reset_n & gnt_valid &  gnt_idx;

    assign gnt_req = gnt_idx ? m1_tla : m0_tla;
    assign hit     = (gnt_req.a_address & addr_mask) == addr_tag;

    always_comb begin
        last_d    = gnt_valid ? gnt_idx : last_q;

        s1_d        = '0;
        s1_d.valid  = gnt_valid & hit;
        s1_d.err    = gnt_valid & ~hit;
        s1_d.owner  = gnt_idx;
        s1_d.source = gnt_req.a_source;

        ram_tla_d = '0;
        if (gnt_valid && hit) begin
            ram_tla_d         = gnt_req;
            ram_tla_d.a_valid = 1'b1;
        end

        s2_d    = s1_q;
        stray_d = stray_q | (ram_tld.d_valid & ~s2_q.valid);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= 1'b1;
            s1_q      <= '0;
            s2_q      <= '0;
            ram_tla_q <= '0;
            stray_q   <= 1'b0;
        end else begin
            last_q    <= last_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            ram_tla_q <= ram_tla_d;
            stray_q   <= stray_d;
        end
    end

    assign ram_tla = ram_tla_q;

    // The response slot owned by s2 goes to its master; the other sees idle.
    always_comb begin
        idle_rsp         = '0;
        idle_rsp.d_ready = 1'b1;

        owner_rsp = idle_rsp;
        if (s2_q.valid) begin
            owner_rsp         = ram_tld;
            owner_rsp.d_ready = 1'b1;
        end else if (s2_q.err) begin
            owner_rsp.d_valid  = 1'b1;
            owner_rsp.d_error  = 1'b1;
            owner_rsp.d_opcode = ACCESS_ACK_DATA;
            owner_rsp.d_source = s2_q.source;
        end

        m0_tld = idle_rsp;
        m1_tld = idle_rsp;
        if (s2_q.owner) begin
            m1_tld = owner_rsp;
        end else begin
            m0_tld = owner_rsp;
        end
    end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter: a small block_ram model answers forwarded
// requests; expected responses are queued per master and checked by a monitor.

module tb_block_ram_arbiter;
    import tilelink_pkg::*;

    logic      clock   = 1'b0;
    logic      reset_n = 1'b0;
    tilelink_a m0_tla, m1_tla, ram_tla;
    tilelink_d m0_tld, m1_tld, ram_tld;
    tilelink_d mdl_tld = '0;
    logic      m0_a_ready, m1_a_ready;
    logic      force_stray = 1'b0;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        logic [3:0]  source;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // RAM model storage; unwritten words read back as 0xA500_0000 | word index.
    logic [31:0] mem [64];
    logic [63:0] written = '0;

    block_ram_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m0_tla     (m0_tla),
        .m1_tla     (m1_tla),
        .m0_a_ready (m0_a_ready),
        .m1_a_ready (m1_a_ready),
        .m0_tld     (m0_tld),
        .m1_tld     (m1_tld),
        .ram_tla    (ram_tla),
        .ram_tld    (ram_tld)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] rd_word(logic [31:0] addr);
        int idx = int'(addr[7:2]);
        return written[idx] ? mem[idx] : (32'hA500_0000 | 32'(idx));
    endfunction

    function automatic tilelink_d ram_resp(tilelink_a a);
        tilelink_d r = '0;
        r.d_ready = 1'b1;
        if (a.a_valid) begin
            r.d_valid  = 1'b1;
            r.d_opcode = ACCESS_ACK_DATA;
            r.d_size   = a.a_size;
            r.d_source = a.a_source;
            r.d_data   = (a.a_opcode == GET) ? rd_word(a.a_address) : a.a_data;
        end
        return r;
    endfunction

    // block_ram model: fixed one-cycle latency, writes echo their data.
    always @(posedge clock) begin
        mdl_tld <= ram_resp(ram_tla);
        if (ram_tla.a_valid && ram_tla.a_opcode != GET) begin
            mem[int'(ram_tla.a_address[7:2])]     <= ram_tla.a_data;
            written[int'(ram_tla.a_address[7:2])] <= 1'b1;
        end
    end

    always_comb begin
        ram_tld = mdl_tld;
        if (force_stray) begin
            ram_tld         = '0;
            ram_tld.d_valid = 1'b1;
            ram_tld.d_data  = 32'h5A5A_5A5A;
        end
    end

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(int m, int due, logic [3:0] src, logic [31:0] data, logic err);
        exp_t e;
        e.due = due; e.source = src; e.data = data; e.err = err;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(int m, tilelink_d d);
        exp_t e;
        if (d.d_valid) begin
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL m%0d_unexpected_rsp: got source=%0d data=%0h want none (cycle %0d)",
                         m, d.d_source, d.d_data, cyc);
            end else begin
                e = (m == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("m%0d_rsp_cycle", m), cyc, e.due);
                check($sformatf("m%0d_rsp_source", m), d.d_source, e.source);
                check($sformatf("m%0d_rsp_data", m), d.d_data, e.data);
                check($sformatf("m%0d_rsp_error", m), d.d_error, e.err);
                check($sformatf("m%0d_rsp_opcode", m), d.d_opcode, ACCESS_ACK_DATA);
                check($sformatf("m%0d_rsp_d_ready", m), d.d_ready, 1'b1);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            mon(0, m0_tld);
            mon(1, m1_tld);
        end
    end

    function automatic tilelink_a get_req(logic [31:0] addr, logic [3:0] src);
        tilelink_a r = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = GET;
        r.a_size    = 2'd2;
        r.a_source  = src;
        r.a_address = addr;
        r.a_mask    = 4'hF;
        r.d_ready   = 1'b1;
        return r;
    endfunction

    function automatic tilelink_a put_req(logic [31:0] addr, logic [31:0] data, logic [3:0] src);
        tilelink_a r = get_req(addr, src);
        r.a_opcode = PUT_FULL_DATA;
        r.a_data   = data;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_grant(string name, logic g0, logic g1);
        #1;
        check({name, "_m0_ready"}, m0_a_ready, g0);
        check({name, "_m1_ready"}, m1_a_ready, g1);
    endtask

    tilelink_d idle_d;

    initial begin
        idle_d         = '0;
        idle_d.d_ready = 1'b1;
        m0_tla = '0;
        m1_tla = '0;

        // Reset state, with a request present so ready masking is visible.
        step();
        m0_tla = get_req(32'h0, 4'd0);
        #1;
        check("rst_m0_ready", m0_a_ready, 1'b0);
        check("rst_ram_tla", ram_tla, '0);
        check("rst_m0_tld", m0_tld, idle_d);
        check("rst_m1_tld", m1_tld, idle_d);
        m0_tla = '0;
        step();
        reset_n = 1'b1;

        // Contention: both masters hold Gets, grants alternate m0, m1, m0, m1.
        step();
        m0_tla = get_req(32'h00, 4'd1);
        m1_tla = get_req(32'h04, 4'd2);
        chk_grant("cont0", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd1, 32'hA500_0000, 1'b0);
        step();
        check("cont1_ram_valid", ram_tla.a_valid, 1'b1);
        check("cont1_ram_addr", ram_tla.a_address, 32'h00);
        m0_tla = get_req(32'h08, 4'd3);
        chk_grant("cont1", 1'b0, 1'b1);
        push_exp(1, cyc + 2, 4'd2, 32'hA500_0001, 1'b0);
        step();
        check("cont2_ram_src", ram_tla.a_source, 4'd2);
        m1_tla = get_req(32'h0C, 4'd4);
        chk_grant("cont2", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd3, 32'hA500_0002, 1'b0);
        step();
        m0_tla = get_req(32'h14, 4'd5);
        chk_grant("cont3", 1'b0, 1'b1);
        push_exp(1, cyc + 2, 4'd4, 32'hA500_0003, 1'b0);
        step();
        m0_tla = '0;  // withdrawn before grant
        m1_tla = '0;
        chk_grant("idle", 1'b0, 1'b0);

        // Single master: write then read back the same word.
        step();
        m0_tla = put_req(32'h10, 32'hDEAD_BEEF, 4'd6);
        chk_grant("put", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd6, 32'hDEAD_BEEF, 1'b0);
        step();
        m0_tla = get_req(32'h10, 4'd7);
        chk_grant("get", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd7, 32'hDEAD_BEEF, 1'b0);
        step();
        m0_tla = '0;

        // Out-of-window request from m1 is answered locally.
        step();
        m1_tla = get_req(32'h4000_0000, 4'd9);
        chk_grant("oow", 1'b0, 1'b1);
        push_exp(1, cyc + 2, 4'd9, 32'h0, 1'b1);
        step();
        m1_tla = '0;
        check("oow_ram_valid", ram_tla.a_valid, 1'b0);
        step();

        // Mixed: error on m0 then a hit on m1 in the next cycle.
        step();
        m0_tla = get_req(32'h8000_0000, 4'd10);
        chk_grant("mix0", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd10, 32'h0, 1'b1);
        step();
        m0_tla = '0;
        m1_tla = get_req(32'h04, 4'd11);
        chk_grant("mix1", 1'b0, 1'b1);
        push_exp(1, cyc + 2, 4'd11, 32'hA500_0001, 1'b0);
        step();
        m1_tla = '0;
        step();
        step();

        // Reset one cycle after a grant: the beat is discarded.
        m0_tla = get_req(32'h08, 4'd12);
        chk_grant("mid", 1'b1, 1'b0);
        step();
        m0_tla = '0;
        check("mid_ram_valid", ram_tla.a_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ram_tla", ram_tla, '0);
        check("mid_rst_m0_tld", m0_tld, idle_d);
        check("mid_rst_m1_tld", m1_tld, idle_d);
        m0_tla = get_req(32'h00, 4'd0);
        #1;
        check("mid_rst_m0_ready", m0_a_ready, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        m0_tla = get_req(32'h00, 4'd13);
        m1_tla = get_req(32'h04, 4'd14);
        chk_grant("post_rst", 1'b1, 1'b0);
        push_exp(0, cyc + 2, 4'd13, 32'hA500_0000, 1'b0);
        step();
        m0_tla = '0;
        chk_grant("post_rst1", 1'b0, 1'b1);
        push_exp(1, cyc + 2, 4'd14, 32'hA500_0001, 1'b0);
        step();
        m1_tla = '0;
        step();
        step();

        // Stray RAM response with nothing outstanding.
        step();
        check("stray_before", dut.stray_q, 1'b0);
        force_stray = 1'b1;
        #1;
        check("stray_m0_dvalid", m0_tld.d_valid, 1'b0);
        check("stray_m1_dvalid", m1_tld.d_valid, 1'b0);
        step();
        force_stray = 1'b0;
        check("stray_flag", dut.stray_q, 1'b1);

        step();
        step();
        step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_ram_arbiter.md
# block_ram_arbiter

Two-master arbiter that shares one `block_ram` TileLink-UL slave between two requesters, e.g. instruction fetch (master 0) and load/store (master 1). It grants one request per cycle by round-robin and registers the granted request toward the RAM. It records which master owns each in-flight beat and steers the RAM's fixed-latency response back to that master. Requests outside the RAM's address window are not forwarded; the arbiter answers them locally with an error response at the same latency.

## Interface
Parameters:
- `addr_mask`, 32'hF0000000, address bits compared for RAM decode; must equal the attached `block_ram` setting.
- `addr_tag`, 32'h00000000, decode value under `addr_mask`.

Ports:
- `clock`  input  1  single clock, all state on posedge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `m0_tla`  input  tilelink_a  master 0 request; held stable until granted.
- `m1_tla`  input  tilelink_a  master 1 request; held stable until granted.
- `m0_a_ready`  output  1  combinational grant to master 0.
- `m1_a_ready`  output  1  combinational grant to master 1.
- `m0_tld`  output  tilelink_d  response to master 0.
- `m1_tld`  output  tilelink_d  response to master 1.
- `ram_tla`  output  tilelink_a  registered request to `block_ram`.
- `ram_tld`  input  tilelink_d  `block_ram` response; valid exactly one cycle after `ram_tla.a_valid`.

## Operation
- Grant, combinational per cycle:
  - Only one master valid: grant it.
  - Both valid: grant the master not granted last (`last_q`).
  - Neither valid: no grant; `last_q` holds.
- `last_q` updates to the granted index on every grant. Reset value is 1, so master 0 wins the first conflict.
- Decode: `hit = (a_address & addr_mask) == addr_tag` on the granted request.
- Stage 1 register (`s1`), loaded every cycle:
  - `s1.valid = grant && hit`, `s1.err = grant && !hit`, `s1.owner = granted index`.
  - On a hit, all `tilelink_a` fields of the granted request are copied into `ram_tla`, with `a_valid=1`.
  - Otherwise `ram_tla.a_valid=0`.
- Stage 2 register (`s2`): copies `s1.valid`, `s1.err` and `s1.owner` one cycle later. It marks the cycle in which the response is due.
- Response steering, combinational from `s2`:
  - `s2.valid`: `ram_tld` goes to `m{owner}_tld`; the other master's `d_valid=0`.
  - `s2.err`:
    - Owner gets `d_valid=1`, `d_error=1`, `d_opcode=AccessAckData`, `d_data=0`.
    - `d_source` = the source captured in `s1`, carried into `s2`.
  - Idle: both `d_valid=0`, `d_error=0`.
  - `d_ready=1` always.
- Masters do not backpressure responses. Any `d_ready` on the master side is ignored, and a response is never stalled.
- `ram_tld.d_valid` arriving while `s2.valid=0` is dropped, and sticky flag `stray_q` is set (debug-visible, internal).
- `ram_tla.d_ready` is unused.

## Timing
- Throughput: one request per cycle total, back-to-back. Alternating grants under continuous contention.
- Latency: grant in cycle N, `ram_tla.a_valid` in N+1, response on `m*_tld` in N+2. Error responses also appear in N+2.
- Reset (`reset_n=0`, asynchronous) clears:
  - `ram_tla.a_valid`, `s1`, `s2` and `stray_q` to 0; `last_q` to 1.
  - All `ram_tla` fields to 0.
  - `m*_tld.d_valid=0`, `d_error=0`, `d_ready=1`, data fields 0.
  - `m*_a_ready` are forced to 0 while `reset_n=0`.
- Reset mid-operation: in-flight beats in `s1`/`s2` are discarded and no response is delivered. A RAM response arriving after release is dropped as stray.
- Same-cycle events:
  - A new grant and the response for an older beat may coexist, and may target the same master.
  - Master-side: one new request plus one earlier response in the same cycle.
- Deassertion of `a_valid` before grant is legal; arbitration re-evaluates every cycle.

## Test plan
- Single master: m0 PutFullData to 0x00000010, data 0xDEADBEEF (cycle 0); m0 Get from 0x00000010 (cycle 1).
  - `m0_a_ready=1` both cycles.
  - `m0_tld`: AccessAckData, data 0xDEADBEEF in cycle 2 (write echo) and in cycle 3 (read).
  - `m1_tld.d_valid` stays 0.
- Contention: both masters hold Get requests for 4 cycles after reset.
  - Grants go m0, m1, m0, m1.
  - Responses arrive two cycles after each grant at the matching master, with the matching `d_source`.
- Out-of-window: m1 Get to 0x40000000.
  - `ram_tla.a_valid` stays 0.
  - Two cycles after grant, `m1_tld` shows `d_valid=1`, `d_error=1`, `d_data=0`.
- Mixed: m0 error request granted in cycle N, m1 hit request granted in N+1.
  - Error on m0 in N+2; RAM data on m1 in N+3; no cross-routing.
- Reset mid-flight: assert `reset_n=0` one cycle after a grant.
  - All outputs are at reset values immediately and asynchronously.
  - No response is delivered after release; the first conflict after release goes to m0.
- Stray: force `ram_tld.d_valid=1` with no request outstanding.
  - Both `m*_tld.d_valid=0`; `stray_q=1`.
